// File: rtl/dac_feeder_pkg.sv
// dac_feeder_pkg: shared types for the sigma-delta DAC feeder
package dac_feeder_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;
endpackage

// File: rtl/dac_feeder_if.sv
// dac_feeder_if: host control and DAC sample bus of the feeder
interface dac_feeder_if #(
   parameter int WIDTH      = 8,
   parameter int DIV_WIDTH  = 16,
   parameter int STEP_WIDTH = 8
);
   logic [DIV_WIDTH-1:0]  div;
   logic [STEP_WIDTH-1:0] step;
   logic                  wr;
   logic [WIDTH-1:0]      wdata;
   logic                  ena_out;
   logic [WIDTH-1:0]      data_out;
   logic                  busy;
   logic                  done;
   modport master (output div, step, wr, wdata, input ena_out, data_out, busy, done);
   modport slave  (input div, step, wr, wdata, output ena_out, data_out, busy, done);
endinterface

// File: rtl/dac_feeder_clk_en_div.sv
// clk_en_div: reloadable down-counter producing a one-clock strobe every div+1 clocks
module clk_en_div #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 tick
);
   logic [DIV_WIDTH-1:0] cnt;
   assign tick = (cnt == '0);
   // reload on tick so div is only sampled once per period
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else        cnt <= tick ? div : cnt - DIV_WIDTH'(1);
endmodule

// File: rtl/dac_feeder.sv
// dac_feeder: prescaled sample strobe plus slew-limited ramp toward a host target
import dac_feeder_pkg::*;
module dac_feeder #(
   parameter int WIDTH      = 8,
   parameter int DIV_WIDTH  = 16,
   parameter int STEP_WIDTH = 8
) (
   input logic        clk,
   input logic        rst_n,
   dac_feeder_if.slave bus
);
   state_t           state, state_d;
   logic [WIDTH-1:0] target, target_d, data, data_d;
   logic             tick, ena, done, done_d, land;
   logic [WIDTH:0]   diff, step_x;
   clk_en_div #(.DIV_WIDTH(DIV_WIDTH)) u_div (.clk(clk), .rst_n(rst_n), .div(bus.div), .tick(tick));
   assign step_x = (WIDTH+1)'(bus.step);
   assign diff   = state == DOWN ? {1'b0, data} - {1'b0, target} : {1'b0, target} - {1'b0, data};
   assign land   = bus.step == '0 || diff <= step_x;
   // next state: a write retargets and skips this tick, otherwise a tick advances one step or lands
   always_comb begin
      state_d  = state;
      target_d = target;
      data_d   = data;
      done_d   = 1'b0;
      if (bus.wr) begin
         target_d = bus.wdata;
         state_d  = bus.wdata > data ? UP : bus.wdata < data ? DOWN : IDLE;
      end else if (tick && state != IDLE) begin
         data_d  = land ? target : state == UP ? data + WIDTH'(bus.step) : data - WIDTH'(bus.step);
         state_d = land ? IDLE : state;
         done_d  = land;
      end
   end
   // registers; ena is delayed one clock so it lines up with the updated data
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= IDLE;
         target <= '0;
         data   <= '0;
         ena    <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_d;
         target <= target_d;
         data   <= data_d;
         ena    <= tick;
         done   <= done_d;
      end
   assign bus.ena_out  = ena;
   assign bus.data_out = data;
   assign bus.busy     = state != IDLE;
   assign bus.done     = done;
endmodule
